// File: rtl/wbucw_serializer.sv
// Drains BW-bit codewords from a FIFO and emits each as NDIG printable base-64 ASCII digits, MSB first.
// Optional macro WBUCW_NEWLINE_EN appends an 8'h0A terminator byte after every codeword.
module wbucw_serializer #(
   parameter int BW = 36
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_fifo_empty_n,
   input  logic [BW-1:0] i_fifo_data,
   output logic          o_fifo_rd,
   output logic          o_stb,
   output logic [7:0]    o_byte,
   input  logic          i_busy,
   output logic          o_active
);

   localparam int NDIG = BW / 6;
   localparam int CW   = $clog2(NDIG + 1);

`ifdef WBUCW_NEWLINE_EN
   localparam logic [CW-1:0] FINAL_DIG = CW'(NDIG - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(NDIG);
`else
   localparam logic [CW-1:0] LAST_CNT  = CW'(NDIG - 1);
`endif

   function automatic logic [7:0] map_digit(input logic [5:0] v);
      logic [7:0] w;
      w = {2'b00, v};
      if (v < 6'd10)
         map_digit = w + 8'h30;
      else if (v < 6'd36)
         map_digit = w + 8'h37;
      else if (v < 6'd62)
         map_digit = w + 8'h3D;
      else if (v == 6'd62)
         map_digit = 8'h40;
      else
         map_digit = 8'h25;
   endfunction

   logic          stb_q,  stb_d;
   logic [7:0]    byte_q, byte_d;
   logic [CW-1:0] cnt_q,  cnt_d;
   logic [BW-1:0] sh_q,   sh_d;
   logic          xfer;
   logic          last;
   logic          rd;

   always_comb begin
      xfer   = stb_q && !i_busy;
      last   = xfer && (cnt_q == LAST_CNT);
      // Popping during reset would lose the word, so the strobe is held off.
      rd     = i_rst_n && i_fifo_empty_n && (!stb_q || last);
      stb_d  = stb_q;
      byte_d = byte_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      if (rd) begin
         sh_d   = i_fifo_data;
         byte_d = map_digit(i_fifo_data[BW-1 -: 6]);
         stb_d  = 1'b1;
         cnt_d  = '0;
      end else if (last) begin
         stb_d  = 1'b0;
      end else if (xfer) begin
         cnt_d  = cnt_q + 1'b1;
         sh_d   = sh_q << 6;
`ifdef WBUCW_NEWLINE_EN
         byte_d = (cnt_q == FINAL_DIG) ? 8'h0A : map_digit(sh_d[BW-1 -: 6]);
`else
         byte_d = map_digit(sh_d[BW-1 -: 6]);
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stb_q  <= 1'b0;
         byte_q <= 8'h00;
         cnt_q  <= '0;
         sh_q   <= '0;
      end else begin
         stb_q  <= stb_d;
         byte_q <= byte_d;
         cnt_q  <= cnt_d;
         sh_q   <= sh_d;
      end
   end

   assign o_fifo_rd = rd;
   assign o_stb     = stb_q;
   assign o_byte    = byte_q;
   assign o_active  = stb_q;

endmodule
